// File: rtl/memory_arbiter.sv
// Purpose: two-master round-robin arbiter in front of a single memory port, one transaction outstanding.
// Latency: request in cycle n -> ready/enable in n+1; completion passes straight through; one idle bubble after each completion.
// Backpressure: memory_ready low holds the current grant indefinitely; the other master's ready stays low.
module memory_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      m0_request,
    output logic                      m0_ready,
    input  logic                      m0_enable,
    input  logic                      m0_command,
    input  logic [ADDRESS_WIDTH-1:0]  m0_address,
    input  logic [DATA_WIDTH-1:0]     m0_write_data,
    input  logic [DATA_WIDTH/8-1:0]   m0_write_strobe,
    output logic                      m0_valid,
    output logic [DATA_WIDTH-1:0]     m0_read_data,

    input  logic                      m1_request,
    output logic                      m1_ready,
    input  logic                      m1_enable,
    input  logic                      m1_command,
    input  logic [ADDRESS_WIDTH-1:0]  m1_address,
    input  logic [DATA_WIDTH-1:0]     m1_write_data,
    input  logic [DATA_WIDTH/8-1:0]   m1_write_strobe,
    output logic                      m1_valid,
    output logic [DATA_WIDTH-1:0]     m1_read_data,

    input  logic                      memory_ready,
    output logic                      memory_enable,
    output logic                      memory_command,
    output logic [ADDRESS_WIDTH-1:0]  memory_address,
    output logic [DATA_WIDTH-1:0]     memory_write_data,
    output logic [DATA_WIDTH/8-1:0]   memory_write_strobe,
    input  logic                      memory_valid,
    input  logic [DATA_WIDTH-1:0]     memory_read_data,

    output logic [1:0]                debug_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        WAIT    = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   last_owner;

    logic   granted;
    logic   waiting;
    logic   owner_request;
    logic   owner_enable;
    logic   issue;

    // Decode the current phase and the owning master's handshake inputs.
    always_comb begin
        granted       = (state == GRANTED);
        waiting       = (state == WAIT);
        owner_request = owner ? m1_request : m0_request;
        owner_enable  = owner ? m1_enable  : m0_enable;
        issue         = granted & memory_ready & owner_enable;
    end

    // Handshake outputs: ready only to the owner while granted, valid only to the owner while waiting.
    always_comb begin
        memory_enable = issue;
        m0_ready      = granted & ~owner & memory_ready;
        m1_ready      = granted &  owner & memory_ready;
        m0_valid      = waiting & ~owner & memory_valid;
        m1_valid      = waiting &  owner & memory_valid;
        m0_read_data  = memory_read_data;
        m1_read_data  = memory_read_data;
        debug_state   = state;
    end

    // Downstream request mux follows the owner while a grant or transaction is live, zero otherwise.
    always_comb begin
        memory_command      = 1'b0;
        memory_address      = '0;
        memory_write_data   = '0;
        memory_write_strobe = '0;
        if (granted || waiting) begin
            memory_command      = owner ? m1_command      : m0_command;
            memory_address      = owner ? m1_address      : m0_address;
            memory_write_data   = owner ? m1_write_data   : m0_write_data;
            memory_write_strobe = owner ? m1_write_strobe : m0_write_strobe;
        end
    end

    // Arbitration state machine; last_owner resets to 1 so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_request && m1_request) begin
                        owner <= ~last_owner;
                        state <= GRANTED;
                    end else if (m0_request) begin
                        owner <= 1'b0;
                        state <= GRANTED;
                    end else if (m1_request) begin
                        owner <= 1'b1;
                        state <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (issue) begin
                        last_owner <= owner;
                        state      <= WAIT;
                    end else if (!owner_request) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (memory_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
